pu_div_sequencer: RTL

Two-requester job scheduler in front of one division processing unit. Arbitrates divide jobs round-robin and drives the PU's sel/wr/oe protocol: write denominator, write numerator, latch, wait out the pipeline, read quotient and remainder. Returns the results with an invalid flag and the requester id through a valid/ready response port. One job in flight at a time.

---
 rtl/pu_div_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/pu_div_sequencer.sv
// Round-robin two-requester job sequencer driving a pipelined division PU over its sel/wr/oe protocol.
// Optional macro DIV_SEQ_ZERO_BYPASS_EN: zero-denominator jobs skip the PU and answer invalid immediately.
module pu_div_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int INVALID    = 0,
    parameter int PIPELINE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_numer,
    input  logic [DATA_WIDTH-1:0] req0_denom,
    input  logic [ATTR_WIDTH-1:0] req0_attr,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_numer,
    input  logic [DATA_WIDTH-1:0] req1_denom,
    input  logic [ATTR_WIDTH-1:0] req1_attr,
    output logic                  pu_signal_sel,
    output logic                  pu_signal_wr,
    output logic                  pu_signal_oe,
    output logic [DATA_WIDTH-1:0] pu_data_in,
    output logic [ATTR_WIDTH-1:0] pu_attr_in,
    input  logic [DATA_WIDTH-1:0] pu_data_out,
    input  logic [ATTR_WIDTH-1:0] pu_attr_out,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [DATA_WIDTH-1:0] resp_quotient,
    output logic [DATA_WIDTH-1:0] resp_remain,
    output logic                  resp_invalid
);

    localparam int CNT_W = $clog2(PIPELINE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_DENOM, S_WR_NUMER, S_LATCH, S_WAIT, S_RD_QUOT, S_RD_REM, S_RESP
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    ptr_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [DATA_WIDTH-1:0]   numer_r;
    logic [ATTR_WIDTH-1:0]   attr_r;

    logic                    grant1_s;
    logic                    accept_s;
    logic                    bypass_s;
    logic [DATA_WIDTH-1:0]   sel_numer_s;
    logic [DATA_WIDTH-1:0]   sel_denom_s;
    logic [ATTR_WIDTH-1:0]   sel_attr_s;

    logic                    sel_next_s;
    logic                    wr_next_s;
    logic                    oe_next_s;
    logic [DATA_WIDTH-1:0]   data_next_s;
    logic [ATTR_WIDTH-1:0]   attr_next_s;

    // Only the invalid bit of the result attributes is consumed.
    logic                    unused_attr_s;
    assign unused_attr_s = ^pu_attr_out;

    // Round-robin grant and operand selection; a lone requester always wins.
    always_comb begin
        grant1_s   = 1'b0;
        accept_s   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req0_valid && req1_valid) begin
            grant1_s = ptr_r;
        end else begin
            grant1_s = req1_valid;
        end
        if (state_r == S_IDLE) begin
            accept_s = req0_valid | req1_valid;
        end else begin
            accept_s = 1'b0;
        end
        req0_ready  = accept_s & ~grant1_s;
        req1_ready  = accept_s & grant1_s;
        sel_numer_s = grant1_s ? req1_numer : req0_numer;
        sel_denom_s = grant1_s ? req1_denom : req0_denom;
        sel_attr_s  = grant1_s ? req1_attr  : req0_attr;
    end

`ifdef DIV_SEQ_ZERO_BYPASS_EN
    assign bypass_s = (sel_denom_s == {DATA_WIDTH{1'b0}});
`else
    assign bypass_s = 1'b0;
`endif

    // Next-state logic of the job sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = bypass_s ? S_RESP : S_WR_DENOM;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WR_DENOM: state_next_s = S_WR_NUMER;
            S_WR_NUMER: state_next_s = S_LATCH;
            S_LATCH:    state_next_s = S_WAIT;
            S_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = S_RD_QUOT;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_RD_QUOT:  state_next_s = S_RD_REM;
            S_RD_REM:   state_next_s = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_RESP;
                end
            end
            default:    state_next_s = S_IDLE;
        endcase
    end

    // PU controls are decoded from the next state so they leave a flop aligned with the state.
    always_comb begin
        sel_next_s  = 1'b0;
        wr_next_s   = 1'b0;
        oe_next_s   = 1'b0;
        data_next_s = {DATA_WIDTH{1'b0}};
        attr_next_s = {ATTR_WIDTH{1'b0}};
        case (state_next_s)
            S_WR_DENOM: begin
                wr_next_s   = 1'b1;
                data_next_s = sel_denom_s;
                attr_next_s = sel_attr_s;
            end
            S_WR_NUMER: begin
                sel_next_s  = 1'b1;
                wr_next_s   = 1'b1;
                data_next_s = numer_r;
                attr_next_s = attr_r;
            end
            S_LATCH: begin
                wr_next_s = 1'b1;
                oe_next_s = 1'b1;
            end
            S_RD_QUOT: oe_next_s = 1'b1;
            S_RD_REM: begin
                oe_next_s  = 1'b1;
                sel_next_s = 1'b1;
            end
            default: begin
                sel_next_s = 1'b0;
            end
        endcase
    end

    // State, job registers, PU drive and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            ptr_r         <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
            numer_r       <= {DATA_WIDTH{1'b0}};
            attr_r        <= {ATTR_WIDTH{1'b0}};
            pu_signal_sel <= 1'b0;
            pu_signal_wr  <= 1'b0;
            pu_signal_oe  <= 1'b0;
            pu_data_in    <= {DATA_WIDTH{1'b0}};
            pu_attr_in    <= {ATTR_WIDTH{1'b0}};
            resp_valid    <= 1'b0;
            resp_id       <= 1'b0;
            resp_quotient <= {DATA_WIDTH{1'b0}};
            resp_remain   <= {DATA_WIDTH{1'b0}};
            resp_invalid  <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            pu_signal_sel <= sel_next_s;
            pu_signal_wr  <= wr_next_s;
            pu_signal_oe  <= oe_next_s;
            pu_data_in    <= data_next_s;
            pu_attr_in    <= attr_next_s;
            resp_valid    <= (state_next_s == S_RESP);
            if (accept_s) begin
                numer_r <= sel_numer_s;
                attr_r  <= sel_attr_s;
                resp_id <= grant1_s;
                ptr_r   <= ~grant1_s;
            end
            if (accept_s && bypass_s) begin
                resp_quotient <= {DATA_WIDTH{1'b0}};
                resp_remain   <= {DATA_WIDTH{1'b0}};
                resp_invalid  <= 1'b1;
            end
            // Loaded so that WAIT lasts exactly PIPELINE cycles.
            if (state_r == S_LATCH) begin
                cnt_r <= CNT_W'(PIPELINE - 1);
            end else if ((state_r == S_WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
            if (state_r == S_RD_QUOT) begin
                resp_quotient <= pu_data_out;
                resp_invalid  <= pu_attr_out[INVALID];
            end
            if (state_r == S_RD_REM) begin
                resp_remain <= pu_data_out;
            end
        end
    end

endmodule
